// File: rtl/i2c_master_lm75_reader.sv
// +----------------------------------------------------------------------------+
// | i2c_master_lm75_reader - I2C master performing one 2-byte LM75 temp read   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module i2c_master_lm75_reader #(
  parameter int         CLK_DIV  = 1000,
  parameter logic [6:0] DEV_ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ack_error,
  output logic [15:0] temp_data,
  output logic        SCL,
  inout  wire         SDA
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, RX_MSB, MSB_ACK, RX_LSB, LSB_NACK, STOP, FINISH
  } state_t;

  localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]       ADDR_BYTE = {DEV_ADDR, 1'b1};

  state_t           state, n_state;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       phase, n_phase;
  logic [2:0]       bit_cnt, n_bit;
  logic [7:0]       shreg, msb;
  logic             ack_bit, sda_low, tick, end_bit;
  logic [1:0]       sda_sync;

  assign SDA     = sda_low ? 1'b0 : 1'bz;
  assign tick    = (div_cnt == DIV_LAST);
  assign end_bit = tick && (phase == 2'd3);

  // {scl, pull SDA low} for a given bus position
  function automatic logic [1:0] bus_drive(state_t s, logic [1:0] p, logic [2:0] b);
    logic pulse;
    pulse = (p == 2'd1) || (p == 2'd2);
    case (s)
      START:    bus_drive = (p == 2'd0) ? 2'b10 : (p == 2'd3) ? 2'b01 : 2'b11;
      ADDR:     bus_drive = {pulse, ~ADDR_BYTE[b]};
      MSB_ACK:  bus_drive = {pulse, 1'b1};
      ADDR_ACK, RX_MSB, RX_LSB, LSB_NACK: bus_drive = {pulse, 1'b0};
      STOP:     bus_drive = (p == 2'd0) ? 2'b01 : (p == 2'd1) ? 2'b11 : 2'b10;
      default:  bus_drive = 2'b10;
    endcase
  endfunction

  always_comb begin
    n_state = state;
    n_phase = phase;
    n_bit   = bit_cnt;
    if (state == IDLE) begin
      if (start) begin
        n_state = START;
        n_phase = 2'd0;
        n_bit   = 3'd7;
      end
    end else if (state == FINISH) begin
      n_state = IDLE;
    end else if (tick) begin
      n_phase = phase + 2'd1;
      if (phase == 2'd3) begin
        n_bit = bit_cnt - 3'd1;
        case (state)
          START:    begin n_state = ADDR; n_bit = 3'd7; end
          ADDR:     if (bit_cnt == 3'd0) n_state = ADDR_ACK;
          ADDR_ACK: begin n_state = ack_bit ? STOP : RX_MSB; n_bit = 3'd7; end
          RX_MSB:   if (bit_cnt == 3'd0) n_state = MSB_ACK;
          MSB_ACK:  begin n_state = RX_LSB; n_bit = 3'd7; end
          RX_LSB:   if (bit_cnt == 3'd0) n_state = LSB_NACK;
          LSB_NACK: n_state = STOP;
          STOP:     n_state = FINISH;
          default:  n_state = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      msb       <= 8'h00;
      ack_bit   <= 1'b0;
      SCL       <= 1'b1;
      sda_low   <= 1'b0;
      sda_sync  <= 2'b11;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
      temp_data <= 16'h0000;
    end else begin
      sda_sync         <= {sda_sync[0], SDA};
      state            <= n_state;
      phase            <= n_phase;
      bit_cnt          <= n_bit;
      div_cnt          <= (state == IDLE || state == FINISH || tick) ? '0 : div_cnt + 1'b1;
      {SCL, sda_low}   <= bus_drive(n_state, n_phase, n_bit);
      done             <= (n_state == FINISH);
      if (state == IDLE && start) begin
        busy      <= 1'b1;
        ack_error <= 1'b0;
      end
      // sample point: last cycle of the second SCL-high phase
      if (tick && phase == 2'd2) begin
        if (state == ADDR_ACK)
          ack_bit <= sda_sync[1];
        else if (state == RX_MSB || state == RX_LSB)
          shreg <= {shreg[6:0], sda_sync[1]};
      end
      if (end_bit) begin
        if (state == ADDR_ACK && ack_bit)
          ack_error <= 1'b1;
        if (state == RX_MSB && bit_cnt == 3'd0)
          msb <= shreg;
        if (state == STOP) begin
          busy <= 1'b0;
          if (!ack_error)
            temp_data <= {msb, shreg};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_lm75_reader.sv
// +----------------------------------------------------------------------------+
// | tb_i2c_master_lm75_reader - bench with LM75 slave model and bus checker    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_master_lm75_reader;
  localparam int CLK_DIV = 4;
  localparam int BIT_CYC = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, ack_error, scl;
  logic [15:0] temp_data;
  wire         sda_bus;
  logic        slave_low;

  assign sda_bus = slave_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_master_lm75_reader #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h48)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .ack_error(ack_error), .temp_data(temp_data), .SCL(scl), .SDA(sda_bus)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int busy_cnt = 0, hi_edges = 0;
  logic [15:0] model_temp = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // LM75 slave: acts on SCL edges seen through clk sampling
  logic       slave_en;
  logic [7:0] msb_val, lsb_val, s_addr;
  logic       s_scl_q, s_sda_q, s_active, s_match;
  int         s_k;

  function automatic logic slave_pull(int k);
    if (k >= 9 && k <= 16)  return ~msb_val[16-k];
    if (k >= 18 && k <= 25) return ~lsb_val[25-k];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      slave_low <= 1'b0; s_active <= 1'b0; s_k <= -1; s_match <= 1'b0;
      s_scl_q <= 1'b1; s_sda_q <= 1'b1; s_addr <= 8'h00;
    end else begin
      s_scl_q <= scl;
      s_sda_q <= sda_bus;
      if (scl && s_scl_q && s_sda_q && !sda_bus) begin
        s_active <= 1'b1; s_k <= -1; s_match <= 1'b0; slave_low <= 1'b0;
      end else if (scl && s_scl_q && !s_sda_q && sda_bus) begin
        s_active <= 1'b0; slave_low <= 1'b0;
      end else if (s_active && scl && !s_scl_q) begin
        if (s_k >= 0 && s_k < 8) s_addr <= {s_addr[6:0], sda_bus};
      end else if (s_active && !scl && s_scl_q) begin
        s_k <= s_k + 1;
        if (s_k + 1 == 8) begin
          s_match   <= slave_en && (s_addr == 8'h91);
          slave_low <= slave_en && (s_addr == 8'h91);
        end else begin
          slave_low <= s_match && slave_pull(s_k + 1);
        end
      end
    end
  end

  // bus checker: SDA edges during SCL high, contention, busy length
  initial begin : bus_checker
    logic p_scl, p_sda;
    p_scl = 1'b1; p_sda = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && scl && p_scl && (sda_bus !== p_sda)) hi_edges++;
      if (slave_low) check("sda_contention", sda_bus, 0);
      if (busy) busy_cnt++;
      p_scl = scl;
      p_sda = sda_bus;
    end
  end

  // expected bus picture, one entry per phase
  logic exp_scl[$], exp_sda[$], exp_chk[$];

  task automatic push_phase(input logic c, input logic d, input logic k);
    exp_scl.push_back(c); exp_sda.push_back(d); exp_chk.push_back(k);
  endtask

  task automatic push_bit(input logic b);
    push_phase(1'b0, b, 1'b1); push_phase(1'b1, b, 1'b1);
    push_phase(1'b1, b, 1'b1); push_phase(1'b0, b, 1'b0);
  endtask

  task automatic build_model(input logic ack, input logic [7:0] m, input logic [7:0] l);
    logic [7:0] ab;
    ab = {7'h48, 1'b1};
    exp_scl.delete(); exp_sda.delete(); exp_chk.delete();
    push_phase(1, 1, 1); push_phase(1, 0, 1); push_phase(1, 0, 1); push_phase(0, 0, 1);
    for (int i = 7; i >= 0; i--) push_bit(ab[i]);
    push_bit(!ack);
    if (ack) begin
      for (int i = 7; i >= 0; i--) push_bit(m[i]);
      push_bit(1'b0);
      for (int i = 7; i >= 0; i--) push_bit(l[i]);
      push_bit(1'b1);
    end
    push_phase(0, 0, 1); push_phase(1, 0, 1); push_phase(1, 1, 1); push_phase(1, 1, 1);
  endtask

  task automatic run_txn(input logic slv, input logic [7:0] m, input logic [7:0] l,
                         input logic poke, input int exp_busy);
    int n;
    slave_en = slv; msb_val = m; lsb_val = l;
    build_model(slv, m, l);
    n = exp_scl.size() * CLK_DIV;
    @(negedge clk);
    start = 1'b1; busy_cnt = 0; hi_edges = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (poke) start = (i == 50 || i == 200 || i == 400);
      check("scl", scl, exp_scl[i / CLK_DIV]);
      if (exp_chk[i / CLK_DIV]) check("sda", sda_bus, exp_sda[i / CLK_DIV]);
      check("busy", busy, 1);
      check("done", done, 0);
    end
    @(negedge clk);
    start = poke;
    if (slv) model_temp = {m, l};
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("ack_error", ack_error, !slv);
    check("temp_data", temp_data, model_temp);
    check("addr_bits", s_addr, 8'h91);
    check("sda_edges_scl_high", hi_edges, 2);
    check("busy_cycles", busy_cnt, exp_busy);
    if (poke) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_scl", scl, 1);
      check("idle_sda", sda_bus, 1);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; slave_en = 1'b0; msb_val = 8'h00; lsb_val = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_error", ack_error, 0);
    check("rst_temp", temp_data, 16'h0000);
    check("rst_scl", scl, 1);
    check("rst_sda", sda_bus, 1);
    reset = 1'b0;
    idle_check(4);

    run_txn(1'b1, 8'h1E, 8'h00, 1'b0, 464);
    check("temp_literal_1e00", temp_data, 16'h1E00);
    idle_check(5);

    run_txn(1'b0, 8'hAA, 8'h55, 1'b0, 176);
    check("temp_kept_literal", temp_data, 16'h1E00);
    check("ack_error_literal", ack_error, 1);
    idle_check(5);

    run_txn(1'b1, 8'hA5, 8'h3C, 1'b1, 464);
    check("temp_literal_a53c", temp_data, 16'hA53C);
    idle_check(20);

    // reset in the middle of MSB bit 4 (bit period 13, SCL high)
    slave_en = 1'b1; msb_val = 8'h1E; lsb_val = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (13 * BIT_CYC + CLK_DIV + 1) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_scl", scl, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_scl", scl, 1);
    check("abort_sda", sda_bus, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_temp", temp_data, 16'h0000);
    model_temp = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_check(4);

    run_txn(1'b1, 8'h1E, 8'h00, 1'b0, 464);
    run_txn(1'b1, 8'h1E, 8'h00, 1'b0, 464);
    check("b2b_temp_literal", temp_data, 16'h1E00);
    idle_check(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
